// File: rtl/snn_addr_router.sv
// Host-bus address router for N SNN cores: decodes core/function fields, hands
// out registered one-cycle strobes and responses, and stalls traffic to busy cores.

module snn_addr_router_chk #(
  parameter int N_CORES = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               rsp_valid,
  input logic               rsp_err,
  input logic [N_CORES-1:0] core_en,
  input logic               spike_in_en,
  input logic               param_in_en,
  input logic               spike_out_en,
  input logic [N_CORES-1:0] calc_start,
  input logic [N_CORES-1:0] busy
);

  a_core_en_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(core_en));

  a_single_action : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({spike_in_en, param_in_en, spike_out_en, |calc_start}));

  a_err_quiet : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_err |-> ((core_en == '0) && !spike_in_en && !param_in_en &&
                 !spike_out_en && (calc_start == '0)));

  a_idle_quiet : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !rsp_valid |-> (!rsp_err && (core_en == '0) && !spike_in_en &&
                    !param_in_en && !spike_out_en && (calc_start == '0)));

  a_start_marks_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((calc_start & ~busy) == '0));

endmodule

module snn_addr_router #(
  parameter int N_CORES  = 2,
  parameter int ADDR_W   = 32,
  parameter int CORE_LSB = 16,
  parameter int CORE_W   = $clog2(N_CORES),
  parameter int FUNC_LSB = CORE_LSB + CORE_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               rsp_valid_o,
  output logic               rsp_err_o,
  output logic [N_CORES-1:0] core_en_o,
  output logic               spike_in_en_o,
  output logic               param_in_en_o,
  output logic               spike_out_en_o,
  output logic [N_CORES-1:0] calc_start_o,
  input  logic [N_CORES-1:0] calc_done_i,
  output logic [N_CORES-1:0] busy_o
);

  localparam logic [1:0] FUNC_SPIKE_IN  = 2'b00;
  localparam logic [1:0] FUNC_PARAM_IN  = 2'b01;
  localparam logic [1:0] FUNC_SPIKE_OUT = 2'b10;
  localparam logic [1:0] FUNC_CALC      = 2'b11;

  localparam logic [CORE_W:0] N_CORES_CMP = (CORE_W+1)'(N_CORES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } busy_state_e;

  logic [CORE_W-1:0]  core_s;
  logic [1:0]         func_s;
  logic               in_range_s;
  logic [N_CORES-1:0] core_hit_s;
  logic               busy_sel_s;
  logic               ready_s;
  logic               dir_ok_s;
  logic               legal_s;
  logic               accept_s;
  logic [N_CORES-1:0] start_s;
  logic [N_CORES-1:0] busy_vec_s;
  logic               unused_addr_s;

  busy_state_e state_r [N_CORES];
  busy_state_e state_s [N_CORES];

  logic               rsp_valid_r;
  logic               rsp_err_r;
  logic [N_CORES-1:0] core_en_r;
  logic               spike_in_en_r;
  logic               param_in_en_r;
  logic               spike_out_en_r;
  logic [N_CORES-1:0] calc_start_r;

  assign core_s        = addr_i[FUNC_LSB-1:CORE_LSB];
  assign func_s        = addr_i[FUNC_LSB+1:FUNC_LSB];
  assign in_range_s    = ({1'b0, core_s} < N_CORES_CMP);
  assign unused_addr_s = ^addr_i;

  // Per-core select and busy lookup; out-of-range cores match nothing.
  always_comb begin
    core_hit_s = '0;
    busy_sel_s = 1'b0;
    for (int c = 0; c < N_CORES; c++) begin
      if (core_s == CORE_W'(c)) begin
        core_hit_s[c] = 1'b1;
        busy_sel_s    = busy_vec_s[c];
      end else begin
        core_hit_s[c] = 1'b0;
      end
    end
  end

  // Stall non-readout traffic to a busy core; never depends on req_valid_i.
  always_comb begin
    if (!rst_ni) begin
      ready_s = 1'b0;
    end else if (in_range_s && busy_sel_s && (func_s != FUNC_SPIKE_OUT)) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  // Direction check for each function code.
  always_comb begin
    case (func_s)
      FUNC_SPIKE_IN:  dir_ok_s = req_we_i;
      FUNC_PARAM_IN:  dir_ok_s = req_we_i;
      FUNC_SPIKE_OUT: dir_ok_s = !req_we_i;
      FUNC_CALC:      dir_ok_s = 1'b1;
      default:        dir_ok_s = 1'b0;
    endcase
  end

  assign legal_s  = in_range_s && dir_ok_s;
  assign accept_s = req_valid_i && ready_s;

  // Calc writes start the addressed core.
  always_comb begin
    if (accept_s && legal_s && (func_s == FUNC_CALC) && req_we_i) begin
      start_s = core_hit_s;
    end else begin
      start_s = '0;
    end
  end

  // Busy FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < N_CORES; c++) begin
        state_r[c] <= ST_IDLE;
      end
    end else begin
      for (int c = 0; c < N_CORES; c++) begin
        state_r[c] <= state_s[c];
      end
    end
  end

  // Busy FSM next state: start moves to BUSY, done returns to IDLE.
  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      state_s[c] = state_r[c];
      case (state_r[c])
        ST_IDLE: begin
          if (start_s[c]) begin
            state_s[c] = ST_BUSY;
          end else begin
            state_s[c] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (calc_done_i[c]) begin
            state_s[c] = ST_IDLE;
          end else begin
            state_s[c] = ST_BUSY;
          end
        end
        default: state_s[c] = ST_IDLE;
      endcase
    end
  end

  // Busy FSM outputs.
  always_comb begin
    busy_vec_s = '0;
    for (int c = 0; c < N_CORES; c++) begin
      if (state_r[c] == ST_BUSY) begin
        busy_vec_s[c] = 1'b1;
      end else begin
        busy_vec_s[c] = 1'b0;
      end
    end
  end

  // One-cycle response and strobes; each accept overwrites the previous cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_r    <= 1'b0;
      rsp_err_r      <= 1'b0;
      core_en_r      <= '0;
      spike_in_en_r  <= 1'b0;
      param_in_en_r  <= 1'b0;
      spike_out_en_r <= 1'b0;
      calc_start_r   <= '0;
    end else if (accept_s) begin
      rsp_valid_r    <= 1'b1;
      rsp_err_r      <= !legal_s;
      core_en_r      <= legal_s ? core_hit_s : '0;
      spike_in_en_r  <= legal_s && (func_s == FUNC_SPIKE_IN);
      param_in_en_r  <= legal_s && (func_s == FUNC_PARAM_IN);
      spike_out_en_r <= legal_s && (func_s == FUNC_SPIKE_OUT);
      calc_start_r   <= start_s;
    end else begin
      rsp_valid_r    <= 1'b0;
      rsp_err_r      <= 1'b0;
      core_en_r      <= '0;
      spike_in_en_r  <= 1'b0;
      param_in_en_r  <= 1'b0;
      spike_out_en_r <= 1'b0;
      calc_start_r   <= '0;
    end
  end

  assign req_ready_o    = ready_s;
  assign rsp_valid_o    = rsp_valid_r;
  assign rsp_err_o      = rsp_err_r;
  assign core_en_o      = core_en_r;
  assign spike_in_en_o  = spike_in_en_r;
  assign param_in_en_o  = param_in_en_r;
  assign spike_out_en_o = spike_out_en_r;
  assign calc_start_o   = calc_start_r;
  assign busy_o         = busy_vec_s;

  snn_addr_router_chk #(
    .N_CORES (N_CORES)
  ) u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rsp_valid    (rsp_valid_r),
    .rsp_err      (rsp_err_r),
    .core_en      (core_en_r),
    .spike_in_en  (spike_in_en_r),
    .param_in_en  (param_in_en_r),
    .spike_out_en (spike_out_en_r),
    .calc_start   (calc_start_r),
    .busy         (busy_vec_s)
  );

endmodule

// File: tb/tb_snn_addr_router.sv
// Directed bench for snn_addr_router: a 2-core and a 3-core instance driven from
// one linear sequence with hand-computed expected output vectors.

module tb_snn_addr_router;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_ni;

  // 2-core instance
  logic        v2, we2, ready2, rv2, re2, si2, pi2, so2;
  logic [31:0] a2;
  logic [1:0]  ce2, cs2, done2, busy2;
  logic [11:0] obs2;

  // 3-core instance
  logic        v3, we3, ready3, rv3, re3, si3, pi3, so3;
  logic [31:0] a3;
  logic [2:0]  ce3, cs3, done3, busy3;
  logic [14:0] obs3;

  int n_cmp = 0;
  int n_err = 0;

  // {ready, rsp_valid, rsp_err, core_en, spike_in, param_in, spike_out, calc_start, busy}
  assign obs2 = {ready2, rv2, re2, ce2, si2, pi2, so2, cs2, busy2};
  assign obs3 = {ready3, rv3, re3, ce3, si3, pi3, so3, cs3, busy3};

  snn_addr_router #(.N_CORES(2)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(v2), .req_ready_o(ready2),
    .req_we_i(we2), .addr_i(a2), .rsp_valid_o(rv2), .rsp_err_o(re2),
    .core_en_o(ce2), .spike_in_en_o(si2), .param_in_en_o(pi2),
    .spike_out_en_o(so2), .calc_start_o(cs2), .calc_done_i(done2), .busy_o(busy2)
  );

  snn_addr_router #(.N_CORES(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(v3), .req_ready_o(ready3),
    .req_we_i(we3), .addr_i(a3), .rsp_valid_o(rv3), .rsp_err_o(re3),
    .core_en_o(ce3), .spike_in_en_o(si3), .param_in_en_o(pi3),
    .spike_out_en_o(so3), .calc_start_o(cs3), .calc_done_i(done3), .busy_o(busy3)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [11:0] exp);
    n_cmp++;
    assert (obs2 === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs2, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [14:0] exp);
    n_cmp++;
    assert (obs3 === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs3, exp);
    end
  endtask

  task automatic chk_rdy2(input string tag, input logic exp);
    n_cmp++;
    assert (ready2 === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, ready2, exp);
    end
  endtask

  initial begin
    // 1. reset with live request and done inputs
    rst_ni = 1'b0;
    v2 = 1'b1; we2 = 1'b1; a2 = 32'h0006_0000; done2 = 2'b11;
    v3 = 1'b1; we3 = 1'b1; a3 = 32'h000E_0000; done3 = 3'b111;
    tick();
    tick();
    chk2("reset_outputs_n2", 12'b0_0_0_00_0_0_0_00_00);
    chk3("reset_outputs_n3", 15'b0_0_0_000_0_0_0_000_000);

    rst_ni = 1'b1; done2 = 2'b00; done3 = 3'b000; v3 = 1'b0;
    a2 = 32'h0000_0000; we2 = 1'b1;
    #1;
    chk_rdy2("ready_after_reset", 1'b1);
    tick();
    chk2("spike_in_core0", 12'b1_1_0_01_1_0_0_00_00);

    // 2. decode sweep, back-to-back
    a2 = 32'h0003_0000; we2 = 1'b1;
    tick();
    chk2("param_in_core1", 12'b1_1_0_10_0_1_0_00_00);
    a2 = 32'h0004_0000; we2 = 1'b0;
    tick();
    chk2("spike_out_core0", 12'b1_1_0_01_0_0_1_00_00);
    v2 = 1'b0;
    tick();
    chk2("strobes_one_cycle", 12'b1_0_0_00_0_0_0_00_00);

    // 3. calc / busy
    v2 = 1'b1; a2 = 32'h0006_0000; we2 = 1'b1;
    tick();
    chk2("calc_start_core0", 12'b0_1_0_01_0_0_0_01_01);
    a2 = 32'h0000_0000; we2 = 1'b1;
    #1;
    chk_rdy2("busy_stall_ready", 1'b0);
    tick();
    chk2("busy_stall_c1", 12'b0_0_0_00_0_0_0_00_01);
    tick();
    chk2("busy_stall_c2", 12'b0_0_0_00_0_0_0_00_01);
    a2 = 32'h0004_0000; we2 = 1'b0;
    #1;
    chk_rdy2("busy_readout_ready", 1'b1);
    tick();
    chk2("busy_readout", 12'b1_1_0_01_0_0_1_00_01);

    // 4. other core unaffected
    a2 = 32'h0001_0000; we2 = 1'b1;
    tick();
    chk2("independent_core1", 12'b1_1_0_10_1_0_0_00_01);

    // 3 cont. done releases the held request one cycle later
    a2 = 32'h0000_0000; we2 = 1'b1; done2 = 2'b01;
    #1;
    chk_rdy2("done_cycle_ready", 1'b0);
    tick();
    done2 = 2'b00;
    chk2("busy_cleared", 12'b1_0_0_00_0_0_0_00_00);
    tick();
    chk2("held_accepted", 12'b1_1_0_01_1_0_0_00_00);

    v2 = 1'b0; done2 = 2'b11;
    tick();
    done2 = 2'b00;
    chk2("done_while_idle", 12'b1_0_0_00_0_0_0_00_00);

    // 5. direction errors and status read
    v2 = 1'b1; a2 = 32'h0000_0000; we2 = 1'b0;
    tick();
    chk2("err_spike_in_read", 12'b1_1_1_00_0_0_0_00_00);
    a2 = 32'h0004_0000; we2 = 1'b1;
    tick();
    chk2("err_spike_out_write", 12'b1_1_1_00_0_0_0_00_00);
    a2 = 32'h0007_0000; we2 = 1'b0;
    tick();
    chk2("status_read_core1", 12'b1_1_0_10_0_0_0_00_00);

    // 6. reset mid-calc
    a2 = 32'h0007_0000; we2 = 1'b1;
    tick();
    chk2("calc_start_core1", 12'b0_1_0_10_0_0_0_10_10);
    v2 = 1'b0;
    tick();
    chk2("core1_busy_idle_bus", 12'b0_0_0_00_0_0_0_00_10);
    rst_ni = 1'b0;
    tick();
    chk2("mid_calc_reset", 12'b0_0_0_00_0_0_0_00_00);
    rst_ni = 1'b1;
    #1;
    chk2("after_reset_release", 12'b1_0_0_00_0_0_0_00_00);
    done2 = 2'b10;
    tick();
    done2 = 2'b00;
    chk2("stray_done_ignored", 12'b1_0_0_00_0_0_0_00_00);

    // 5 cont. 3-core instance: out-of-range core with core2 busy
    v3 = 1'b1; a3 = 32'h000E_0000; we3 = 1'b1;
    tick();
    chk3("n3_calc_core2", 15'b0_1_0_100_0_0_0_100_100);
    a3 = 32'h0003_0000; we3 = 1'b1;
    tick();
    chk3("n3_err_core3", 15'b1_1_1_000_0_0_0_000_100);
    a3 = 32'h0000_0000; we3 = 1'b0;
    tick();
    chk3("n3_err_spike_in_read", 15'b1_1_1_000_0_0_0_000_100);
    a3 = 32'h000A_0000; we3 = 1'b0;
    tick();
    chk3("n3_readout_core2", 15'b1_1_0_100_0_0_1_000_100);
    v3 = 1'b0; done3 = 3'b100;
    tick();
    done3 = 3'b000;
    chk3("n3_core2_done", 15'b1_0_0_000_0_0_0_000_000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
